// File: rtl/pwm_pkg.sv
// Shared types and constants for the H-bridge PWM driver.
package pwm_pkg;

   localparam int PERIOD_W = 13;
   localparam int unsigned DEADTIME_DEF = 16;
   localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   // |d| of a 14-bit two's-complement value; -8192 saturates to 8191.
   function automatic logic [PERIOD_W-1:0] abs_sat(input logic [PERIOD_W:0] d);
      if (d == {1'b1, {PERIOD_W{1'b0}}}) begin
         return PERIOD_MAX;
      end
      return d[PERIOD_W] ? PERIOD_W'(~d[PERIOD_W-1:0] + 1'b1) : d[PERIOD_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_drive.sv
// Sign/magnitude H-bridge PWM: fixed 8192-cycle period, dead time on reversal, outputs 1 cycle after counter.
// Optional PWM_CLAMP_EN limits the magnitude to MAX_MAG.
module pwm_drive
   import pwm_pkg::*;
#(
   parameter int unsigned DEADTIME = DEADTIME_DEF,
   parameter int unsigned MAX_MAG  = 7936
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [13:0] duty,
   input  logic               duty_vld,
   input  logic               en,
   output logic               pwm_fwd,
   output logic               pwm_rev,
   output logic               period_end
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] mag_q, mag_d;
   logic [PERIOD_W:0]   shadow_q, shadow_d;
   logic                dir_q, dir_d;
   logic                run_q;
   logic [7:0]          dead_q, dead_d;
   state_t              state_q, state_d;
   logic                fwd_q, rev_q, pe_q;
   logic                fwd_d, rev_d, pe_d;

   logic [PERIOD_W-1:0] abs_mag;
   logic [PERIOD_W-1:0] mag_new;
   logic                dir_new;
   logic                period_start;
   logic                drive_on;

   assign abs_mag = abs_sat(shadow_q);
   assign dir_new = shadow_q[PERIOD_W];

`ifdef PWM_CLAMP_EN
   assign mag_new = (abs_mag > PERIOD_W'(MAX_MAG)) ? PERIOD_W'(MAX_MAG) : abs_mag;
`else
   logic unused_max_mag;
   assign unused_max_mag = ^MAX_MAG;
   assign mag_new        = abs_mag;
`endif

   // A period begins at the natural wrap or on the first enabled cycle after en was low.
   assign period_start = en && (!run_q || (cnt_q == PERIOD_MAX));

   always_comb begin
      shadow_d = duty_vld ? duty : shadow_q;
      cnt_d    = cnt_q;
      mag_d    = mag_q;
      dir_d    = dir_q;
      dead_d   = dead_q;
      state_d  = state_q;
      if (!en) begin
         cnt_d   = '0;
         dead_d  = '0;
         state_d = ST_IDLE;
      end else if (period_start) begin
         cnt_d = '0;
         mag_d = mag_new;
         dir_d = dir_new;
         if (mag_new == '0) begin
            state_d = ST_IDLE;
         end else if (dir_new != dir_q) begin
            state_d = ST_DEAD;
            dead_d  = 8'(DEADTIME - 1);
         end else begin
            state_d = ST_DRIVE;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
         if (state_q == ST_DEAD) begin
            if (dead_q == '0) begin
               state_d = ST_DRIVE;
            end else begin
               dead_d = dead_q - 1'b1;
            end
         end
      end
   end

   assign drive_on = en && (state_q == ST_DRIVE) && (cnt_q < mag_q);
   assign fwd_d    = drive_on && !dir_q;
   assign rev_d    = drive_on && dir_q;
   assign pe_d     = en && (cnt_q == (PERIOD_MAX - 1'b1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         mag_q    <= '0;
         shadow_q <= '0;
         dir_q    <= 1'b0;
         run_q    <= 1'b0;
         dead_q   <= '0;
         state_q  <= ST_IDLE;
         fwd_q    <= 1'b0;
         rev_q    <= 1'b0;
         pe_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         mag_q    <= mag_d;
         shadow_q <= shadow_d;
         dir_q    <= dir_d;
         run_q    <= en;
         dead_q   <= dead_d;
         state_q  <= state_d;
         fwd_q    <= fwd_d;
         rev_q    <= rev_d;
         pe_q     <= pe_d;
      end
   end

   assign pwm_fwd    = fwd_q;
   assign pwm_rev    = rev_q;
   assign period_end = pe_q;

endmodule

// File: doc/pwm_drive.md
PWM_DRIVE -- requirements
Module: pwm_drive

Interface
REQ-001 SHALL have parameter DEADTIME, default 16, meaning both-outputs-low cycles inserted on direction reversal (1..255).
REQ-002 SHALL have parameter MAX_MAG, default 7936, meaning the magnitude clamp ceiling used only when PWM_CLAMP_EN is defined.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port duty  input  14  signed two's-complement duty command from the PID stage.
REQ-006 SHALL have port duty_vld  input  1  one-cycle strobe qualifying duty.
REQ-007 SHALL have port en  input  1  drive enable; low forces outputs off.
REQ-008 SHALL have port pwm_fwd  output  1  forward bridge drive, registered.
REQ-009 SHALL have port pwm_rev  output  1  reverse bridge drive, registered.
REQ-010 SHALL have port period_end  output  1  one-cycle pulse in the last cycle of each PWM period.

Function
REQ-011 SHALL run a 13-bit period counter 0..8191, wrapping to 0, giving a fixed 8192-cycle period while en=1.
REQ-012 SHALL capture duty into a shadow register on any cycle with duty_vld=1; the last strobe within a period wins.
REQ-013 SHALL transfer shadow to active (sign -> dir, |duty| -> mag) only at counter wrap (8191 -> 0); a strobe in the wrap cycle itself is applied at the following wrap.
REQ-014 SHALL compute mag as 13-bit |duty|, saturating -8192 to 8191.
REQ-015 SHALL implement FSM states IDLE, DRIVE, DEAD.
REQ-016 IDLE: both outputs 0; go to DRIVE at the first wrap with new mag != 0.
REQ-017 DRIVE: the selected output (dir=0 -> pwm_fwd, dir=1 -> pwm_rev) SHALL be 1 exactly while counter < mag, otherwise 0; the other output SHALL stay 0.
REQ-018 At a wrap where new mag = 0, the FSM SHALL go to IDLE.
REQ-019 At a wrap where new dir differs from the current dir and new mag != 0, the FSM SHALL enter DEAD.
REQ-020 DEAD SHALL hold both outputs 0 for DEADTIME cycles, then enter DRIVE with the new dir; the counter keeps running, so the first pulse is shortened by DEADTIME.
REQ-021 pwm_fwd and pwm_rev SHALL never be 1 in the same cycle.
REQ-022 Each output SHALL have latency of exactly one cycle from the counter value it is compared against.
REQ-023 en=0 SHALL force outputs 0 next cycle, hold counter at 0, and put the FSM in IDLE with shadow retained.
REQ-024 On en rising, a new period SHALL start at counter 0, with the shadow applied as at a wrap and DEAD entered if dir changed.
REQ-025 mag = 8191 SHALL give an 8191-high, 1-low waveform; 100% duty is unreachable by design.

Reset
REQ-026 On rst_n=0, asynchronously: pwm_fwd=0, pwm_rev=0, period_end=0, counter=0, shadow=0, mag=0, dir=0, FSM=IDLE.
REQ-027 Reset asserted mid-period or mid-DEAD SHALL abort immediately, with no residual dead-time after release.

Configuration
REQ-028 Macro PWM_CLAMP_EN, when defined, SHALL clamp mag to min(|duty|, MAX_MAG) before the wrap transfer.
REQ-029 Without PWM_CLAMP_EN, mag SHALL use the full 0..8191 range, and MAX_MAG SHALL be unused.

Structure
REQ-030 Package pwm_pkg SHALL hold the FSM state enum, PERIOD_W=13, and DEADTIME default.
REQ-031 The block SHALL contain no sub-module; dead-time counter and comparator are inline.

Verification
REQ-032 duty=14'h0800 strobed, en=1 -> from next wrap, pwm_fwd high 2048 cycles per 8192-cycle period, pwm_rev 0.
REQ-033 duty=+1000 then -1000 mid-period -> at wrap both low 16 cycles, then pwm_rev high cycles 16..999, then 1000 per later period.
REQ-034 duty=14'h2000 (-8192) -> pwm_rev high 8191 of 8192 cycles; with PWM_CLAMP_EN, 7936 cycles.
REQ-035 Strobes 500, 3000, 1200 within one period -> next period pwm_fwd high 1200 cycles; strobe in wrap cycle is deferred one period.
REQ-036 rst_n low during DEAD then released, en=1, shadow 0 -> outputs 0, FSM IDLE, no pulse until a nonzero strobe and wrap.
REQ-037 Random duty/en/reset stream -> assertion that pwm_fwd & pwm_rev never both 1.
